alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 64-bit ALU between two requesters: req0, the execute-stage datapath, and req1, the branch/address-generation unit.
- Per-requester valid/ready issue handshake. Two register stages: an issue register (S1) that drives the ALU, and a response register (S2) that captures aluout/zero.
- Full throughput of one operation per cycle. Fixed latency of 2 cycles from handshake to response.
- Sits between the requesters and the alu modport of alu_if.

Parameters:
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with req0 winning.
- CNT_W, 32, width of the performance counters (only used with ALU_ARB_PERF_EN).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- flush  input  1  squash all in-flight operations.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_porta, req0_portb / req1_porta, req1_portb  input  64  operands (dword_t).
- req0_aluop / req1_aluop  input  aluop_t  operation.
- rsp0_valid / rsp1_valid  output  1  result valid, one-cycle pulse.
- rsp0_aluout / rsp1_aluout  output  64  result.
- rsp0_zero / rsp1_zero  output  1  zero flag for the result.
- alu_porta, alu_portb  output  64  ALU operands.
- alu_aluop  output  aluop_t  ALU operation.
- alu_aluout  input  64  ALU result.
- alu_zero  input  1  ALU zero flag.
- busy  output  1  S1 or S2 holds a valid operation.
- perf_grant0, perf_grant1, perf_conflict  output  CNT_W  counters (ALU_ARB_PERF_EN only).

Behaviour:
- Reset: one clock, asynchronous active-low reset on nRST. Outputs and state at reset:
  - S1/S2 valid bits = 0; all rspN_valid = 0; busy = 0.
  - All data registers = 0, so rspN_aluout = 0 and rspN_zero = 0.
  - Round-robin pointer rr_ptr = 0 (req0 preferred).
  - Perf counters = 0.
- Arbitration is combinational within the cycle. reqN_ready may depend on both valids; a requester must not make valid depend on ready.
  - flush = 1: both readys = 0.
  - Only one requester valid: that requester is granted.
  - Both valid, PRIO_MODE=1: grant req0.
  - Both valid, PRIO_MODE=0: grant req rr_ptr.
  - On every grant, rr_ptr <= not(granted id), so a lone requester does not lose its alternation.
- Handshake: valid & ready at edge k loads S1 with {valid=1, id, porta, portb, aluop}. S1 never stalls because S2 has no backpressure; every cycle's grant is accepted.
- ALU drive: while S1 is valid, alu_porta/alu_portb/alu_aluop come directly from the S1 registers. While S1 is empty, the ALU is driven with porta = 0, portb = 0, aluop = aluop_t'(0).
- Response: at edge k+1, S2 captures alu_aluout, alu_zero and id from S1.
  - rsp<id>_valid = 1 for exactly the cycle after edge k+1, i.e. 2 cycles after the request cycle. The other rsp valid stays 0.
  - rspN_aluout/zero hold their last captured value while rspN_valid = 0. Only the addressed requester's data registers update.
- Back-to-back: consecutive grants produce consecutive responses in grant order. Requester ids may interleave.
- Flush: synchronous.
  - At the flush edge, S1.valid <= 0 and S2 capture is suppressed (all rspN_valid <= 0).
  - Responses already visible in the flush cycle still complete.
  - No request is accepted in the flush cycle.
- Reset mid-operation: all in-flight work is dropped immediately and no response is emitted.
- busy = S1.valid | any rspN_valid.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - perf_grant0 and perf_grant1 increment on each grant to req0 / req1.
  - perf_conflict increments on each cycle where both valids are high and flush = 0.
  - All three counters saturate at 2^CNT_W-1, are cleared only by nRST, and ignore flush.
- Undefined: the three perf ports and their counters are absent. Arbitration and timing are identical in both builds.

Test Plan:
- Single op: reset, then req0 valid in cycle 3 with porta=5, portb=7, aluop=ADD -> req0_ready=1 in cycle 3; alu ports 5/7/ADD in cycle 4; rsp0_valid=1 in cycle 5 with aluout=12, zero=0; rsp1_valid stays 0.
- Round-robin contention (PRIO_MODE=0): both valid for 4 cycles after reset -> grant order 0,1,0,1; responses alternate 2 cycles later; perf_conflict=4 and perf_grant0=perf_grant1=2 when ALU_ARB_PERF_EN is defined.
- Fixed priority (PRIO_MODE=1): both valid for 3 cycles -> req1_ready stays 0; req0 is granted 3 times.
- Zero flag and hold: req1 SUB with porta=portb=0xFFFF_FFFF_FFFF_FFFF -> rsp1_valid pulse with aluout=0, zero=1; rsp1_aluout holds 0 afterwards while req0 results change only the rsp0 outputs.
- Flush: grant req0 in cycle k, flush=1 in cycle k+1 -> no rsp0_valid in cycle k+2; readys are 0 in cycle k+1; busy=0 by cycle k+2.
- Async reset: assert nRST low mid-cycle while S1 and S2 are valid -> all valids and busy drop immediately, rr_ptr returns to 0, and no response appears after release.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared 64-bit ALU: issue register (S1) feeds the ALU,
// response register (S2) returns the result two cycles after the handshake. Perf counters: ALU_ARB_PERF_EN.
module alu_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 32,
  parameter int OP_W      = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [63:0]      req0_porta,
  input  logic [63:0]      req0_portb,
  input  logic [63:0]      req1_porta,
  input  logic [63:0]      req1_portb,
  input  logic [OP_W-1:0]  req0_aluop,
  input  logic [OP_W-1:0]  req1_aluop,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [63:0]      rsp0_aluout,
  output logic [63:0]      rsp1_aluout,
  output logic             rsp0_zero,
  output logic             rsp1_zero,
  output logic [63:0]      alu_porta,
  output logic [63:0]      alu_portb,
  output logic [OP_W-1:0]  alu_aluop,
  input  logic [63:0]      alu_aluout,
  input  logic             alu_zero,
  output logic             busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_grant0,
  output logic [CNT_W-1:0] perf_grant1,
  output logic [CNT_W-1:0] perf_conflict
`endif
);

  logic            grant0, grant1;
  logic            rrPtr_q, rrPtr_d;
  logic            s1Valid_q, s1Valid_d;
  logic            s1Id_q, s1Id_d;
  logic [63:0]     s1PortA_q, s1PortA_d;
  logic [63:0]     s1PortB_q, s1PortB_d;
  logic [OP_W-1:0] s1Op_q, s1Op_d;
  logic            rsp0Valid_q, rsp0Valid_d;
  logic            rsp1Valid_q, rsp1Valid_d;
  logic [63:0]     rsp0Out_q, rsp0Out_d;
  logic [63:0]     rsp1Out_q, rsp1Out_d;
  logic            rsp0Zero_q, rsp0Zero_d;
  logic            rsp1Zero_q, rsp1Zero_d;
  logic            capture;

  // rrPtr_q = 0 means req0 wins the next tie; it always points away from the last winner.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!flush) begin
      if (req0_valid && req1_valid) begin
        if (PRIO_MODE == 1 || !rrPtr_q) grant0 = 1'b1;
        else                             grant1 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    rrPtr_d   = rrPtr_q;
    s1Valid_d = grant0 | grant1;
    s1Id_d    = s1Id_q;
    s1PortA_d = s1PortA_q;
    s1PortB_d = s1PortB_q;
    s1Op_d    = s1Op_q;
    if (grant0) begin
      rrPtr_d   = 1'b1;
      s1Id_d    = 1'b0;
      s1PortA_d = req0_porta;
      s1PortB_d = req0_portb;
      s1Op_d    = req0_aluop;
    end else if (grant1) begin
      rrPtr_d   = 1'b0;
      s1Id_d    = 1'b1;
      s1PortA_d = req1_porta;
      s1PortB_d = req1_portb;
      s1Op_d    = req1_aluop;
    end
  end

  // Flush kills the operation sitting in S1; a response already in S2 is left to finish.
  assign capture = s1Valid_q & ~flush;

  always_comb begin
    rsp0Valid_d = capture & ~s1Id_q;
    rsp1Valid_d = capture & s1Id_q;
    rsp0Out_d   = rsp0Out_q;
    rsp0Zero_d  = rsp0Zero_q;
    rsp1Out_d   = rsp1Out_q;
    rsp1Zero_d  = rsp1Zero_q;
    if (rsp0Valid_d) begin
      rsp0Out_d  = alu_aluout;
      rsp0Zero_d = alu_zero;
    end
    if (rsp1Valid_d) begin
      rsp1Out_d  = alu_aluout;
      rsp1Zero_d = alu_zero;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rrPtr_q     <= 1'b0;
      s1Valid_q   <= 1'b0;
      s1Id_q      <= 1'b0;
      s1PortA_q   <= '0;
      s1PortB_q   <= '0;
      s1Op_q      <= '0;
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
      rsp0Out_q   <= '0;
      rsp1Out_q   <= '0;
      rsp0Zero_q  <= 1'b0;
      rsp1Zero_q  <= 1'b0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      s1Valid_q   <= s1Valid_d;
      s1Id_q      <= s1Id_d;
      s1PortA_q   <= s1PortA_d;
      s1PortB_q   <= s1PortB_d;
      s1Op_q      <= s1Op_d;
      rsp0Valid_q <= rsp0Valid_d;
      rsp1Valid_q <= rsp1Valid_d;
      rsp0Out_q   <= rsp0Out_d;
      rsp1Out_q   <= rsp1Out_d;
      rsp0Zero_q  <= rsp0Zero_d;
      rsp1Zero_q  <= rsp1Zero_d;
    end
  end

  // An idle ALU sees all-zero operands so its inputs do not toggle with stale data.
  assign alu_porta   = s1Valid_q ? s1PortA_q : '0;
  assign alu_portb   = s1Valid_q ? s1PortB_q : '0;
  assign alu_aluop   = s1Valid_q ? s1Op_q : '0;

  assign rsp0_valid  = rsp0Valid_q;
  assign rsp1_valid  = rsp1Valid_q;
  assign rsp0_aluout = rsp0Out_q;
  assign rsp1_aluout = rsp1Out_q;
  assign rsp0_zero   = rsp0Zero_q;
  assign rsp1_zero   = rsp1Zero_q;
  assign busy        = s1Valid_q | rsp0Valid_q | rsp1Valid_q;

`ifdef ALU_ARB_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] grant0Cnt_q, grant0Cnt_d;
  logic [CNT_W-1:0] grant1Cnt_q, grant1Cnt_d;
  logic [CNT_W-1:0] conflictCnt_q, conflictCnt_d;

  // Saturating counters; only reset clears them, flush has no effect.
  always_comb begin
    grant0Cnt_d   = grant0Cnt_q;
    grant1Cnt_d   = grant1Cnt_q;
    conflictCnt_d = conflictCnt_q;
    if (grant0 && grant0Cnt_q != '1) grant0Cnt_d = grant0Cnt_q + CntOne;
    if (grant1 && grant1Cnt_q != '1) grant1Cnt_d = grant1Cnt_q + CntOne;
    if (req0_valid && req1_valid && !flush && conflictCnt_q != '1)
      conflictCnt_d = conflictCnt_q + CntOne;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant0Cnt_q   <= '0;
      grant1Cnt_q   <= '0;
      conflictCnt_q <= '0;
    end else begin
      grant0Cnt_q   <= grant0Cnt_d;
      grant1Cnt_q   <= grant1Cnt_d;
      conflictCnt_q <= conflictCnt_d;
    end
  end

  assign perf_grant0   = grant0Cnt_q;
  assign perf_grant1   = grant1Cnt_q;
  assign perf_conflict = conflictCnt_q;
`endif

endmodule
